aes_req_ctrl: RTL and testbench

//  Request front-end for aes_top: accepts encrypt/decrypt jobs on a valid/ready port, sequences ld

---
 rtl/aes_req_ctrl.sv | 157 +++++++++++++++
 tb/tb_aes_req_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_req_ctrl.sv
// Request front-end for the AES cipher / inverse-cipher cores: accepts jobs, sequences ld pulses,
// waits on done/kdone under a watchdog and returns the result. It also caches the last expanded decrypt key.
module aes_req_ctrl #(
    parameter int TIMEOUT_CYC = 256,
    parameter int KEY_CACHE   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_mode,
    input  logic [127:0] req_key,
    input  logic [127:0] req_text,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_text,
    output logic         rsp_mode,
    output logic         rsp_err,
    output logic         enc_ld,
    output logic         dec_ld,
    output logic [127:0] core_key,
    output logic [127:0] core_text,
    input  logic         enc_done,
    input  logic [127:0] enc_text,
    input  logic         dec_kdone,
    input  logic         dec_done,
    input  logic [127:0] dec_text
);

    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        ENC_LD,
        ENC_WAIT,
        DKEY_LD,
        DKEY_WAIT,
        DEC_LD,
        DEC_WAIT,
        RSP
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [WDW-1:0] wdog;
    logic [127:0]   cache_key;
    logic           cache_valid;

    logic accept;
    logic cache_hit;
    logic in_ld;
    logic in_wait;
    logic wait_ok;
    logic expired;
    logic timeout;

    assign accept    = req_valid && req_ready;
    assign cache_hit = (KEY_CACHE != 0) && cache_valid && (req_key == cache_key);
    assign in_ld     = (state == ENC_LD) || (state == DKEY_LD) || (state == DEC_LD);
    assign in_wait   = (state == ENC_WAIT) || (state == DKEY_WAIT) || (state == DEC_WAIT);
    // Completion is only honoured in the wait state that owns it, so stray pulses fall through.
    assign wait_ok   = ((state == ENC_WAIT)  && enc_done)  ||
                       ((state == DKEY_WAIT) && dec_kdone) ||
                       ((state == DEC_WAIT)  && dec_done);
    assign expired   = (wdog == WDW'(TIMEOUT_CYC - 1));
    assign timeout   = in_wait && !wait_ok && expired;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!req_mode) begin
                        state_next = ENC_LD;
                    end else if (cache_hit) begin
                        state_next = DEC_LD;
                    end else begin
                        state_next = DKEY_LD;
                    end
                end
            end
            ENC_LD:    state_next = ENC_WAIT;
            ENC_WAIT:  if (enc_done || timeout) state_next = RSP;
            DKEY_LD:   state_next = DKEY_WAIT;
            DKEY_WAIT: begin
                if (dec_kdone) begin
                    state_next = DEC_LD;
                end else if (timeout) begin
                    state_next = RSP;
                end
            end
            DEC_LD:    state_next = DEC_WAIT;
            DEC_WAIT:  if (dec_done || timeout) state_next = RSP;
            RSP:       if (rsp_ready) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RSP);
        enc_ld    = (state == ENC_LD);
        dec_ld    = (state == DKEY_LD) || (state == DEC_LD);
    end

    // Job capture, result register, watchdog and key cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            core_key    <= '0;
            core_text   <= '0;
            rsp_mode    <= 1'b0;
            rsp_text    <= '0;
            rsp_err     <= 1'b0;
            wdog        <= '0;
            cache_key   <= '0;
            cache_valid <= 1'b0;
        end else begin
            if (accept) begin
                core_key  <= req_key;
                core_text <= req_text;
                rsp_mode  <= req_mode;
            end

            if (in_ld) begin
                wdog <= '0;
            end else if (in_wait && !wait_ok && !expired) begin
                wdog <= wdog + WDW'(1);
            end

            if ((state == ENC_WAIT) && enc_done) begin
                rsp_text <= enc_text;
                rsp_err  <= 1'b0;
            end else if ((state == DEC_WAIT) && dec_done) begin
                rsp_text <= dec_text;
                rsp_err  <= 1'b0;
            end else if (timeout) begin
                rsp_text    <= '0;
                rsp_err     <= 1'b1;
                cache_valid <= 1'b0;
            end

            if ((state == DKEY_WAIT) && dec_kdone) begin
                cache_key   <= core_key;
                cache_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_req_ctrl.sv
// Self-checking bench for aes_req_ctrl: emulates both AES cores and compares every response
// against a job-level model (expected text, ld pulse counts, key cache, latency).
module tb_aes_req_ctrl;

    localparam int TIMEOUT_CYC = 256;
    localparam int KEY_CACHE   = 1;

    localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic         req_mode = 1'b0;
    logic [127:0] req_key = '0;
    logic [127:0] req_text = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [127:0] rsp_text;
    logic         rsp_mode;
    logic         rsp_err;
    logic         enc_ld;
    logic         dec_ld;
    logic [127:0] core_key;
    logic [127:0] core_text;
    logic         enc_done = 1'b0;
    logic [127:0] enc_text = '0;
    logic         dec_kdone = 1'b0;
    logic         dec_done = 1'b0;
    logic [127:0] dec_text = '0;

    int checks = 0;
    int failures = 0;
    int enc_pulses = 0;
    int dec_pulses = 0;
    int last_lat = 0;
    logic core_hold = 1'b0;
    logic dec_key_next = 1'b0;
    logic m_valid = 1'b0;
    logic [127:0] m_key = '0;
    logic [127:0] m_last_text = '0;

    aes_req_ctrl #(.TIMEOUT_CYC(TIMEOUT_CYC), .KEY_CACHE(KEY_CACHE)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
        .req_key(req_key), .req_text(req_text),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text),
        .rsp_mode(rsp_mode), .rsp_err(rsp_err),
        .enc_ld(enc_ld), .dec_ld(dec_ld), .core_key(core_key), .core_text(core_text),
        .enc_done(enc_done), .enc_text(enc_text),
        .dec_kdone(dec_kdone), .dec_done(dec_done), .dec_text(dec_text)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (enc_ld) enc_pulses++;
        if (dec_ld) dec_pulses++;
    end

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Stand-in core functions: the real FIPS-197 vector for K1, a keyed mixing otherwise.
    function automatic logic [127:0] enc_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == K1 && t == P1) return C1;
        return t ^ {k[63:0], k[127:64]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    endfunction

    function automatic logic [127:0] dec_fn(input logic [127:0] k, input logic [127:0] t);
        if (k == K1 && t == C1) return P1;
        return t ^ k ^ 128'h5a5a5a5a_c3c3c3c3_96969696_0f0f0f0f;
    endfunction

    task automatic serve();
        int  lat;
        logic key_phase;
        lat = $urandom_range(1, 5);
        if (enc_ld) begin
            last_lat = lat;
            repeat (lat) begin @(posedge clk); #1; end
            enc_text = enc_fn(core_key, core_text);
            enc_done = 1'b1;
            @(posedge clk); #1;
            enc_done = 1'b0;
            enc_text = rnd128();
        end else begin
            key_phase = dec_key_next;
            dec_key_next = 1'b0;
            repeat (lat) begin @(posedge clk); #1; end
            if (key_phase) begin
                dec_kdone = 1'b1;
            end else begin
                dec_text = dec_fn(core_key, core_text);
                dec_done = 1'b1;
            end
            @(posedge clk); #1;
            dec_kdone = 1'b0;
            dec_done  = 1'b0;
            dec_text  = rnd128();
        end
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            while ((enc_ld || dec_ld) && !core_hold) serve();
        end
    end

    task automatic check_reset_values(input string name);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_mode, enc_ld, dec_ld} !== 6'b100000 ||
            rsp_text !== '0 || core_key !== '0 || core_text !== '0) begin
            failures++;
            $display("[TB] FAIL %s: flags rdy/vld/err/mode/enc_ld/dec_ld=%b text=%h key=%h ctext=%h, required 100000 and zeros",
                     name, {req_ready, rsp_valid, rsp_err, rsp_mode, enc_ld, dec_ld}, rsp_text, core_key, core_text);
        end
    endtask

    task automatic run_job(input logic mode, input logic [127:0] key, input logic [127:0] text,
                           input int delay, input logic hold);
        int e0, d0, cyc, exp_enc, exp_dec, exp_lat;
        logic hit, busy_bad, unstable;
        logic [127:0] exp_text, snap;
        hit      = (KEY_CACHE != 0) && m_valid && (key == m_key);
        exp_enc  = mode ? 0 : 1;
        exp_dec  = mode ? (hit ? 1 : 2) : 0;
        exp_text = hold ? 128'h0 : (mode ? dec_fn(key, text) : enc_fn(key, text));
        busy_bad = 1'b0;
        unstable = 1'b0;
        core_hold = hold;
        dec_key_next = mode && !hit;

        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL idle_ready: req_ready=%b, required 1", req_ready);
        end
        e0 = enc_pulses;
        d0 = dec_pulses;
        req_valid = 1'b1; req_mode = mode; req_key = key; req_text = text;
        @(negedge clk);
        req_valid = 1'b0; req_key = rnd128(); req_text = rnd128(); req_mode = $urandom_range(0, 1);
        cyc = 1;
        while (!rsp_valid && cyc < TIMEOUT_CYC + 64) begin
            if (req_ready) busy_bad = 1'b1;
            @(negedge clk);
            cyc++;
        end
        core_hold = 1'b0;

        checks++;
        if (!rsp_valid) begin
            failures++;
            $display("[TB] FAIL rsp_wait: rsp_valid=0 after %0d cycles, required 1", cyc);
        end
        checks++;
        if (busy_bad) begin
            failures++;
            $display("[TB] FAIL busy_ready: req_ready=1 while busy, required 0");
        end
        checks++;
        if (rsp_text !== exp_text) begin
            failures++;
            $display("[TB] FAIL rsp_text: got %h, required %h", rsp_text, exp_text);
        end
        checks++;
        if (rsp_err !== hold || rsp_mode !== mode) begin
            failures++;
            $display("[TB] FAIL rsp_err_mode: err=%b mode=%b, required err=%b mode=%b", rsp_err, rsp_mode, hold, mode);
        end
        checks++;
        if (enc_pulses - e0 != exp_enc || dec_pulses - d0 != exp_dec) begin
            failures++;
            $display("[TB] FAIL ld_pulses: enc=%0d dec=%0d, required enc=%0d dec=%0d",
                     enc_pulses - e0, dec_pulses - d0, exp_enc, exp_dec);
        end
        if (!mode) begin
            exp_lat = hold ? TIMEOUT_CYC + 2 : last_lat + 2;
            checks++;
            if (cyc != exp_lat) begin
                failures++;
                $display("[TB] FAIL enc_latency: %0d cycles, required %0d", cyc, exp_lat);
            end
        end

        snap = rsp_text;
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_text !== snap || req_ready) unstable = 1'b1;
        end
        if (delay > 0) begin
            checks++;
            if (unstable) begin
                failures++;
                $display("[TB] FAIL rsp_hold: vld=%b text=%h rdy=%b, required 1 %h 0", rsp_valid, rsp_text, req_ready, snap);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rsp_handshake: rsp_valid=%b req_ready=%b, required 0 1", rsp_valid, req_ready);
        end

        if (hold) begin
            m_valid = 1'b0;
        end else if (mode) begin
            m_valid = 1'b1;
            m_key   = key;
        end
        m_last_text = exp_text;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rst = 1'b0;
        m_valid = 1'b0;
        m_last_text = '0;
        @(negedge clk);
        check_reset_values("reset_first_cycle");
    endtask

    task automatic test_encrypt();
        run_job(1'b0, K1, P1, 0, 1'b0);
    endtask

    task automatic test_decrypt_cache();
        run_job(1'b1, K1, C1, 0, 1'b0);
        run_job(1'b1, K1, C1, 2, 1'b0);
    endtask

    task automatic test_cache_miss();
        run_job(1'b1, K2, rnd128(), 0, 1'b0);
        run_job(1'b1, K2, rnd128(), 1, 1'b0);
    endtask

    task automatic test_timeout();
        run_job(1'b0, K1, P1, 0, 1'b1);
        run_job(1'b1, K2, rnd128(), 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_job(1'b0, rnd128(), rnd128(), 10, 1'b0);
    endtask

    task automatic test_stray_idle();
        logic bad;
        bad = 1'b0;
        enc_done = 1'b1; dec_kdone = 1'b1; dec_done = 1'b1;
        enc_text = rnd128(); dec_text = rnd128();
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || !req_ready || enc_ld || dec_ld || rsp_text !== m_last_text) bad = 1'b1;
        end
        enc_done = 1'b0; dec_kdone = 1'b0; dec_done = 1'b0;
        @(negedge clk);
        checks++;
        if (bad || rsp_valid || rsp_text !== m_last_text) begin
            failures++;
            $display("[TB] FAIL stray_idle: rsp_valid=%b req_ready=%b text=%h, required 0 1 %h",
                     rsp_valid, req_ready, rsp_text, m_last_text);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic seen;
        run_job(1'b1, K1, C1, 0, 1'b0);
        core_hold = 1'b1;
        @(negedge clk);
        req_valid = 1'b1; req_mode = 1'b1; req_key = K1; req_text = C1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset_mid_wait");
        rst = 1'b0;
        core_hold = 1'b0;
        dec_key_next = 1'b0;
        m_valid = 1'b0;
        m_last_text = '0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid || enc_ld || dec_ld) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("[TB] FAIL dropped_job: activity after reset, required none");
        end
        run_job(1'b1, K1, C1, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [127:0] key;
        for (int n = 0; n < 16; n++) begin
            case ($urandom_range(0, 2))
                0:       key = K1;
                1:       key = K2;
                default: key = rnd128();
            endcase
            run_job(1'($urandom_range(0, 1)), key, rnd128(), $urandom_range(0, 3), 1'b0);
        end
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "[TB] hang");
    end

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt_cache();
        test_cache_miss();
        test_timeout();
        test_back_to_back();
        test_stray_idle();
        test_reset_mid_wait();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
